// File: rtl/dcache_pkg.sv
// Shared definitions for the write-through data cache: access sizes, FSM states
// and address-field width helpers derived from the cache geometry.
package dcache_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      REFILL_REQ  = 2'd1,
      REFILL_WAIT = 2'd2
   } state_e;

   function automatic int word_idx_bits(input int wpl);
      return $clog2(wpl);
   endfunction

   function automatic int line_off_bits(input int wpl);
      return $clog2(wpl) + 2;
   endfunction

   function automatic int set_idx_bits(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_bits(input int sets, input int wpl);
      return 32 - $clog2(sets) - $clog2(wpl) - 2;
   endfunction

endpackage

// File: rtl/dcache_lane_align.sv
// Byte-lane steering: load extract/extend and store replicate/strobe generation.
// Purely combinational, zero latency, no flow control.
module dcache_lane_align
   import dcache_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        sign_ext_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] load_word_i,
   input  logic [31:0] store_data_i,
   output logic [31:0] load_data_o,
   output logic [31:0] store_wdata_o,
   output logic [3:0]  store_wstrb_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign byte_v = 8'(load_word_i >> {offset_i, 3'b000});
   assign half_v = offset_i[1] ? load_word_i[31:16] : load_word_i[15:0];

   // Unsupported size encoding 2'b11 behaves as a word access.
   always_comb begin
      load_data_o   = load_word_i;
      store_wdata_o = store_data_i;
      store_wstrb_o = 4'b1111;
      case (size_i)
         SIZE_BYTE: begin
            load_data_o   = {{24{sign_ext_i & byte_v[7]}}, byte_v};
            store_wdata_o = {4{store_data_i[7:0]}};
            store_wstrb_o = 4'b0001 << offset_i;
         end
         SIZE_HALF: begin
            load_data_o   = {{16{sign_ext_i & half_v[15]}}, half_v};
            store_wdata_o = {2{store_data_i[15:0]}};
            store_wstrb_o = offset_i[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through no-write-allocate D-cache: hits return same cycle,
// misses stall for a line burst, stores stall until the backing memory accepts.
module dcache_wt
   import dcache_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int SETS           = 16,
   parameter int WORDS_PER_LINE = 4
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  mem_write,
   input  logic [1:0]            type_control,
   input  logic                  sign_ext_flag,
   input  logic [31:0]           addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  stall,
   output logic                  mem_req_valid,
   output logic                  mem_req_we,
   output logic [31:0]           mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_wstrb,
   input  logic                  mem_req_ready,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int WB    = word_idx_bits(WORDS_PER_LINE);
   localparam int LOB   = line_off_bits(WORDS_PER_LINE);
   localparam int SB    = set_idx_bits(SETS);
   localparam int TAG_W = tag_bits(SETS, WORDS_PER_LINE);
   localparam logic [WB-1:0] LAST_BEAT = WB'(WORDS_PER_LINE - 1);

   state_e                state_q;
   logic [WB-1:0]         cnt_q;
   logic [31:0]           line_addr_q;
   logic [SETS-1:0]       valid_q;
   logic [TAG_W-1:0]      tag_q  [SETS];
   logic [DATA_WIDTH-1:0] data_q [SETS][WORDS_PER_LINE];

   logic [TAG_W-1:0] req_tag, refill_tag;
   logic [SB-1:0]    req_set, refill_set;
   logic [WB-1:0]    req_word;
   logic             hit, load_req, store_req, last_beat;
   logic [31:0]      ld_data, st_wdata;
   logic [3:0]       st_wstrb;

   assign req_tag    = addr[31 -: TAG_W];
   assign req_set    = addr[LOB +: SB];
   assign req_word   = addr[2 +: WB];
   assign refill_tag = line_addr_q[31 -: TAG_W];
   assign refill_set = line_addr_q[LOB +: SB];

   assign hit       = valid_q[req_set] && (tag_q[req_set] == req_tag);
   assign load_req  = (state_q == IDLE) && req_valid && !mem_write;
   assign store_req = (state_q == IDLE) && req_valid && mem_write;
   assign last_beat = (state_q == REFILL_WAIT) && mem_rvalid && (cnt_q == LAST_BEAT);

   dcache_lane_align u_align (
      .size_i        (type_control),
      .sign_ext_i    (sign_ext_flag),
      .offset_i      (addr[1:0]),
      .load_word_i   (data_q[req_set][req_word]),
      .store_data_i  (write_data),
      .load_data_o   (ld_data),
      .store_wdata_o (st_wdata),
      .store_wstrb_o (st_wstrb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         line_addr_q <= '0;
         valid_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (load_req && !hit) begin
                  // The set is about to be overwritten; keep it invalid until the last beat.
                  valid_q[req_set] <= 1'b0;
                  line_addr_q      <= {addr[31:LOB], {LOB{1'b0}}};
                  state_q          <= REFILL_REQ;
               end
            end
            REFILL_REQ: begin
               if (mem_req_ready) begin
                  cnt_q   <= '0;
                  state_q <= REFILL_WAIT;
               end
            end
            REFILL_WAIT: begin
               if (mem_rvalid) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (last_beat) begin
                     valid_q[refill_set] <= 1'b1;
                     state_q             <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Tag and data arrays carry no reset; valid_q gates every use of them.
   always_ff @(posedge clk) begin
      if ((state_q == REFILL_WAIT) && mem_rvalid) begin
         data_q[refill_set][cnt_q] <= mem_rdata;
         if (last_beat) tag_q[refill_set] <= refill_tag;
      end
      if (store_req && mem_req_ready && hit) begin
         for (int b = 0; b < 4; b++) begin
            if (st_wstrb[b]) data_q[req_set][req_word][8*b +: 8] <= st_wdata[8*b +: 8];
         end
      end
   end

   always_comb begin
      read_data     = '0;
      stall         = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_we    = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      mem_wstrb     = '0;
      case (state_q)
         IDLE: begin
            if (load_req) begin
               if (hit) read_data = ld_data;
               else     stall     = 1'b1;
            end
            if (store_req) begin
               mem_req_valid = 1'b1;
               mem_req_we    = 1'b1;
               mem_addr      = {addr[31:2], 2'b00};
               mem_wdata     = st_wdata;
               mem_wstrb     = st_wstrb;
               stall         = !mem_req_ready;
            end
         end
         REFILL_REQ: begin
            stall         = 1'b1;
            mem_req_valid = 1'b1;
            mem_addr      = line_addr_q;
         end
         REFILL_WAIT: stall = 1'b1;
         default: stall = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: the initial block plays both the pipeline and the
// backing memory, stepping cycle by cycle against hand-computed values.
module tb_dcache_wt;
   import dcache_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, mem_write, sign_ext_flag;
   logic [1:0]  type_control;
   logic [31:0] addr, write_data, read_data;
   logic        stall, mem_req_valid, mem_req_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        mem_req_ready, mem_rvalid;

   int n_assert = 0;
   int n_fail   = 0;
   logic [31:0] bmem [logic [31:0]];

   always #5 clk = ~clk;

   dcache_wt #(.DATA_WIDTH(32), .SETS(16), .WORDS_PER_LINE(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .mem_write     (mem_write),
      .type_control  (type_control),
      .sign_ext_flag (sign_ext_flag),
      .addr          (addr),
      .write_data    (write_data),
      .read_data     (read_data),
      .stall         (stall),
      .mem_req_valid (mem_req_valid),
      .mem_req_we    (mem_req_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_wstrb     (mem_wstrb),
      .mem_req_ready (mem_req_ready),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] bm(input logic [31:0] a);
      return bmem.exists(a) ? bmem[a] : 32'h0;
   endfunction

   task automatic req(input logic we, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] wd);
      req_valid     = 1'b1;
      mem_write     = we;
      type_control  = sz;
      sign_ext_flag = sx;
      addr          = a;
      write_data    = wd;
   endtask

   // Called with a missing load already driven; returns in the first IDLE cycle after the burst.
   task automatic load_miss(input string tag, input logic [31:0] line, input int accept_wait, input int gap_at);
      #1;
      check({tag, "_miss_stall"}, {31'b0, stall}, 32'h1);
      check({tag, "_miss_noreq"}, {31'b0, mem_req_valid}, 32'h0);
      cyc(); #1;
      check({tag, "_rreq_valid"}, {31'b0, mem_req_valid}, 32'h1);
      check({tag, "_rreq_we"}, {31'b0, mem_req_we}, 32'h0);
      check({tag, "_rreq_addr"}, mem_addr, line);
      for (int i = 0; i < accept_wait; i++) begin
         cyc(); #1;
         check({tag, "_rreq_hold"}, {31'b0, mem_req_valid & stall}, 32'h1);
      end
      mem_req_ready = 1'b1;
      cyc();
      mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == gap_at) begin
            mem_rvalid = 1'b0;
            #1;
            check({tag, "_gap_stall"}, {31'b0, stall}, 32'h1);
            cyc();
         end
         mem_rvalid = 1'b1;
         mem_rdata  = bm(32'(line + 32'(4 * i)));
         #1;
         check({tag, "_beat_stall"}, {31'b0, stall}, 32'h1);
         cyc();
      end
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; mem_write = 1'b0; type_control = SIZE_WORD;
      sign_ext_flag = 1'b0; addr = '0; write_data = '0;
      mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      bmem[32'h100] = 32'hDEADBEEF; bmem[32'h104] = 32'h11111111;
      bmem[32'h108] = 32'h22222222; bmem[32'h10C] = 32'h33333333;
      bmem[32'h200] = 32'hCAFEF00D; bmem[32'h300] = 32'h0BADF00D;

      repeat (3) cyc();
      rst = 1'b0;
      cyc(); #1;
      check("rst_stall", {31'b0, stall}, 32'h0);
      check("rst_mreq", {31'b0, mem_req_valid}, 32'h0);
      check("rst_we", {31'b0, mem_req_we}, 32'h0);
      check("rst_maddr", mem_addr, 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      check("rst_wstrb", {28'b0, mem_wstrb}, 32'h0);
      check("rst_rdata", read_data, 32'h0);

      // Cold miss: 1 + 1 accept + 4 beats of stall, then hit.
      cyc(); req(1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0);
      load_miss("lw100", 32'h100, 0, -1);
      #1;
      check("lw100_data", read_data, 32'hDEADBEEF);
      check("lw100_nostall", {31'b0, stall}, 32'h0);

      // Sub-word hits, signed/unsigned, including misaligned forcing.
      cyc(); req(1'b0, SIZE_BYTE, 1'b1, 32'h103, 32'h0); #1;
      check("lb103", read_data, 32'hFFFFFFDE);
      check("lb103_noreq", {31'b0, mem_req_valid | stall}, 32'h0);
      cyc(); req(1'b0, SIZE_BYTE, 1'b0, 32'h103, 32'h0); #1;
      check("lbu103", read_data, 32'h000000DE);
      cyc(); req(1'b0, SIZE_HALF, 1'b1, 32'h102, 32'h0); #1;
      check("lh102", read_data, 32'hFFFFDEAD);
      cyc(); req(1'b0, SIZE_HALF, 1'b1, 32'h101, 32'h0); #1;
      check("lh101_misal", read_data, 32'hFFFFBEEF);
      cyc(); req(1'b0, SIZE_BYTE, 1'b0, 32'h104, 32'h0); #1;
      check("lbu104", read_data, 32'h00000011);
      cyc(); req(1'b0, SIZE_WORD, 1'b0, 32'h10E, 32'h0); #1;
      check("lw10E_misal", read_data, 32'h33333333);

      // Half store hit held off by mem_req_ready for 3 cycles.
      cyc(); req(1'b1, SIZE_HALF, 1'b0, 32'h102, 32'h1234ABCD); #1;
      check("sh_stall0", {31'b0, stall}, 32'h1);
      check("sh_we", {31'b0, mem_req_valid & mem_req_we}, 32'h1);
      check("sh_addr", mem_addr, 32'h100);
      cyc(); #1; check("sh_stall1", {31'b0, stall}, 32'h1);
      cyc(); #1; check("sh_stall2", {31'b0, stall}, 32'h1);
      cyc(); mem_req_ready = 1'b1; #1;
      check("sh_accept_stall", {31'b0, stall}, 32'h0);
      check("sh_wdata", mem_wdata, 32'hABCDABCD);
      check("sh_wstrb", {28'b0, mem_wstrb}, 32'hC);
      bmem[32'h100] = 32'hABCDBEEF;
      cyc(); req(1'b1, SIZE_BYTE, 1'b0, 32'h105, 32'h0000005A); #1;
      check("sb_wdata", mem_wdata, 32'h5A5A5A5A);
      check("sb_wstrb", {28'b0, mem_wstrb}, 32'h2);
      bmem[32'h104] = 32'h11115A11;
      cyc(); mem_req_ready = 1'b0; req(1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0); #1;
      check("lw100_after_sh", read_data, 32'hABCDBEEF);
      check("lw100_after_sh_stall", {31'b0, stall | mem_req_valid}, 32'h0);
      cyc(); req(1'b0, SIZE_WORD, 1'b0, 32'h104, 32'h0); #1;
      check("lw104_after_sb", read_data, 32'h11115A11);

      // Store miss does not allocate.
      cyc(); mem_req_ready = 1'b1; req(1'b1, SIZE_WORD, 1'b0, 32'h2000, 32'h12345678); #1;
      check("sw2000_addr", mem_addr, 32'h2000);
      check("sw2000_wdata", mem_wdata, 32'h12345678);
      check("sw2000_wstrb", {28'b0, mem_wstrb}, 32'hF);
      check("sw2000_stall", {31'b0, stall}, 32'h0);
      bmem[32'h2000] = 32'h12345678;
      cyc(); mem_req_ready = 1'b0; req(1'b0, SIZE_WORD, 1'b0, 32'h2000, 32'h0);
      load_miss("lw2000", 32'h2000, 0, -1);
      #1; check("lw2000_data", read_data, 32'h12345678);

      // Conflicting tags in set 0, with accept wait and a beat gap.
      cyc(); req(1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0);
      load_miss("lw100b", 32'h100, 2, -1);
      #1; check("lw100b_data", read_data, 32'hABCDBEEF);
      cyc(); req(1'b0, SIZE_WORD, 1'b0, 32'h200, 32'h0);
      load_miss("lw200", 32'h200, 0, 2);
      #1; check("lw200_data", read_data, 32'hCAFEF00D);
      cyc(); req(1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0);
      load_miss("lw100c", 32'h100, 0, -1);
      #1; check("lw100c_data", read_data, 32'hABCDBEEF);

      // Reset in the middle of a refill burst.
      cyc(); req(1'b0, SIZE_WORD, 1'b0, 32'h300, 32'h0); #1;
      check("lw300_stall", {31'b0, stall}, 32'h1);
      cyc(); mem_req_ready = 1'b1; #1;
      check("lw300_raddr", mem_addr, 32'h300);
      cyc(); mem_req_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = bm(32'h300);
      cyc(); mem_rdata = bm(32'h304);
      cyc(); mem_rvalid = 1'b0; rst = 1'b1; req_valid = 1'b0;
      cyc(); rst = 1'b0; #1;
      check("abort_stall", {31'b0, stall}, 32'h0);
      check("abort_mreq", {31'b0, mem_req_valid}, 32'h0);
      mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
      cyc(); mem_rvalid = 1'b0; #1;
      check("stray_stall", {31'b0, stall | mem_req_valid}, 32'h0);
      cyc(); req(1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0);
      load_miss("lw100d", 32'h100, 0, -1);
      #1; check("lw100d_data", read_data, 32'hABCDBEEF);

      cyc(); req_valid = 1'b0; #1;
      check("idle_end", {31'b0, stall | mem_req_valid}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the memory pipeline stage (the requester) and a word-wide backing data memory.
- It is the responder to memory-stage loads and stores and the initiator of line refills and write-through stores toward the backing memory.
- While a request cannot complete in the current cycle it asserts stall, and the pipeline holds the memory stage.

Parameters:
DATA_WIDTH, 32, word width in bits (only 32 supported)
SETS, 16, number of lines (power of 2)
WORDS_PER_LINE, 4, words per line; also the refill burst length (power of 2)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  1  memory stage has a load or store this cycle
mem_write  input  1  1 = store, 0 = load
type_control  input  2  access size: 00 byte, 01 half, 10 word
sign_ext_flag  input  1  1 = sign-extend sub-word loads, 0 = zero-extend
addr  input  32  byte address
write_data  input  32  store data, right-aligned
read_data  output  32  load result, extended per sign_ext_flag
stall  output  1  request not yet complete; hold the pipeline
mem_req_valid  output  1  backing-memory request
mem_req_we  output  1  1 = write word, 0 = line-read burst
mem_addr  output  32  word address for writes; line-aligned address for reads
mem_wdata  output  32  write data, lane-shifted
mem_wstrb  output  4  byte write enables
mem_req_ready  input  1  backing memory accepts the request this cycle
mem_rvalid  input  1  refill beat valid
mem_rdata  input  32  refill beat data, in ascending word order

Behaviour:
- Address split: offset [1:0], word index [log2(WPL)+1:2], set index next log2(SETS) bits, tag the remainder.
- Access alignment:
  - Misaligned accesses are forced aligned: half ignores addr[0], word ignores addr[1:0].
  - Byte lane = addr[1:0]; half lane = addr[1].
- Reset:
  - FSM goes to IDLE; all valid bits clear; refill counter = 0.
  - Outputs: stall 0, mem_req_valid 0, mem_req_we 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, read_data 0.
- FSM states: IDLE, REFILL_REQ, REFILL_WAIT.
- IDLE, load hit (valid[set] and tag match):
  - read_data is combinational in the same cycle; stall = 0.
  - Zero added latency.
- IDLE, load miss:
  - stall = 1.
  - Register the line address (addr with low log2(WPL)+2 bits cleared) and go to REFILL_REQ.
- REFILL_REQ:
  - mem_req_valid = 1, mem_req_we = 0, mem_addr = registered line address.
  - On mem_req_ready, go to REFILL_WAIT with counter = 0.
  - stall = 1.
- REFILL_WAIT:
  - Each cycle with mem_rvalid: write mem_rdata into data[set][counter], then counter++.
  - On the beat where counter = WPL-1: set tag[set], set valid[set], return to IDLE.
  - stall = 1.
  - The next IDLE cycle re-looks-up and hits. Total load-miss stall = 1 + accept wait + WPL beats (+ gaps).
- IDLE, store (hit or miss):
  - Drive combinationally: mem_req_valid = 1, mem_req_we = 1, mem_addr = addr with [1:0] cleared.
  - mem_wdata: byte replicated ×4; half replicated ×2; word unchanged.
  - mem_wstrb: byte 0001<<addr[1:0]; half 0011<<(2·addr[1]); word 1111.
  - stall = ~mem_req_ready.
  - In the accept cycle, on a hit, strobed lanes of data[set][word] are updated. A store miss does not allocate.
- Idle outputs: req_valid = 0 in IDLE gives stall = 0 and mem_req_valid = 0.
- Load extension:
  - Byte selects lane addr[1:0].
  - Half selects lane addr[1].
  - Bit 7/15 is replicated if sign_ext_flag, else zeros.
- Boundaries and ordering:
  - mem_rvalid outside REFILL_WAIT is ignored.
  - req inputs are ignored outside IDLE; the requester holds them stable while stall = 1.
  - rst mid-refill aborts to IDLE with the line left invalid. The backing memory is reset by the same rst and drops in-flight beats.
  - A store immediately after a refill sees the updated line; there is no concurrent outstanding request, so there are no ordering hazards.
- Counter wraps only via the last-beat transition; tags/data are not reset (valid gates them).

Decomposition:
- Package dcache_pkg holds:
  - access-size localparams (SIZE_BYTE, SIZE_HALF, SIZE_WORD);
  - FSM state enum;
  - address-field width functions.
- One sub-module, dcache_lane_align: combinational load extract/extend and store replicate/strobe generation. It is reused for read_data, mem_wdata and mem_wstrb.

Test Plan:
- Reset, then lw addr 0x100 (backing word 0xDEADBEEF) → stall for 1 + accept + 4 beats, refill request at 0x100; next cycle read_data = 0xDEADBEEF, stall 0.
- After that refill, lb addr 0x103 with sign_ext 1 → 0xFFFFFFDE same cycle, no mem request; lbu → 0x000000DE.
- sh 0xABCD at 0x102 (hit) with mem_req_ready held low 3 cycles → stall 3 cycles, then mem_wstrb = 1100, mem_wdata = 0xABCDABCD; subsequent lw 0x100 hits = 0xABCDBEEF.
- sw to unmapped-line address 0x2000 → one write request, no refill; following lw 0x2000 misses and issues a refill.
- Conflicting tags: lw 0x100 then lw 0x100 + SETS·16 → second evicts first; lw 0x100 misses again.
- Assert rst during REFILL_WAIT after 2 beats → IDLE, stall 0; stray mem_rvalid ignored; lw 0x100 misses and refetches.
